// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory access path: RV32I load/store
// funct3 encodings, the load/store unit state type and its default timeout.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a bus word and sign- or
// zero-extends it according to the RV32I load type.
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [31:0] busRdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] loadData
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by extension for the requested access width
    always_comb begin
        case (addr)
            2'd0:    byte_lane = busRdata[7:0];
            2'd1:    byte_lane = busRdata[15:8];
            2'd2:    byte_lane = busRdata[23:16];
            default: byte_lane = busRdata[31:24];
        endcase
        half_lane = addr[1] ? busRdata[31:16] : busRdata[15:0];

        case (funct3)
            F3_B:    loadData = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    loadData = {{16{half_lane[15]}}, half_lane};
            F3_BU:   loadData = {24'd0, byte_lane};
            F3_HU:   loadData = {16'd0, half_lane};
            default: loadData = busRdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: checks each core access for legality and alignment,
// issues one registered bus transaction, stalls the core until the bus
// acknowledges or times out, and returns the extended load result.
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        fault,
    output logic        busErr,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWdata,
    output logic [3:0]  busBe,
    input  logic        busAck,
    input  logic [31:0] busRdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] read_data_q, read_data_d;
    logic        fault_q, fault_d;
    logic        bus_err_q, bus_err_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        req;
    logic        type_ok;
    logic        align_ok;
    logic        legal;
    logic [31:0] store_data;
    logic [3:0]  store_be;
    logic [31:0] ext_data;
    logic        stall_c;

    load_extend u_load_extend (
        .busRdata (busRdata),
        .addr     (off_q),
        .funct3   (f3_q),
        .loadData (ext_data)
    );

    // Legality check plus store lane replication and byte-enable generation
    always_comb begin
        req = memRead | memWrite;
        if (memWrite) begin
            type_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            type_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                      (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        case (funct3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
        legal = type_ok & align_ok;

        case (funct3[1:0])
            2'b00: begin
                store_data = {4{writeData[7:0]}};
                store_be   = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                store_data = {2{writeData[15:0]}};
                store_be   = 4'b0011 << addr[1:0];
            end
            default: begin
                store_data = writeData;
                store_be   = 4'b1111;
            end
        endcase
    end

    // Next-state, bus register updates and combinational stall
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        fault_d     = 1'b0;
        bus_err_d   = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        f3_d        = f3_q;
        off_d       = off_q;
        stall_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (legal) begin
                        stall_c     = 1'b1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = memWrite;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_wdata_d = memWrite ? store_data : '0;
                        bus_be_d    = memWrite ? store_be : 4'b1111;
                        f3_d        = funct3;
                        off_d       = addr[1:0];
                        cnt_d       = '0;
                        state_d     = BUS;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            BUS: begin
                stall_c = 1'b1;
                if (busAck) begin
                    if (!bus_we_q) begin
                        read_data_d = ext_data;
                    end
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (!bus_we_q) begin
                        read_data_d = '0;
                    end
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            fault_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            f3_q        <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            fault_q     <= fault_d;
            bus_err_q   <= bus_err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
        end
    end

    assign stall    = stall_c & ~reset;
    assign readData = read_data_q;
    assign fault    = fault_q;
    assign busErr   = bus_err_q;
    assign busReq   = bus_req_q;
    assign busWe    = bus_we_q;
    assign busAddr  = bus_addr_q;
    assign busWdata = bus_wdata_q;
    assign busBe    = bus_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses, each compared against a byte-level reference model.
module tb_load_store_unit;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, writeData;
    logic [31:0] readData;
    logic        stall, fault, busErr, busReq, busWe;
    logic [31:0] busAddr, busWdata;
    logic [3:0]  busBe;
    logic        busAck;
    logic [31:0] busRdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rd_model;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .funct3    (funct3),
        .addr      (addr),
        .writeData (writeData),
        .readData  (readData),
        .stall     (stall),
        .fault     (fault),
        .busErr    (busErr),
        .busReq    (busReq),
        .busWe     (busWe),
        .busAddr   (busAddr),
        .busWdata  (busWdata),
        .busBe     (busBe),
        .busAck    (busAck),
        .busRdata  (busRdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load result: shift the addressed bytes down, then extend
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] d);
        int unsigned nbytes = 1 << f3[1:0];
        int unsigned sh = 8 * (a % 4);
        logic [31:0] v;
        logic [31:0] mask;
        v = d >> sh;
        if (nbytes < 4) begin
            mask = (32'd1 << (8 * nbytes)) - 32'd1;
            v = v & mask;
            if (f3[2] == 1'b0 && v[8 * nbytes - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    // One core access; waits = bus cycles without ack before the ack cycle
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits, input bit ack_in_done);
        bit          is_st, legal, timeout, stable, done;
        int unsigned nbytes, bus_cycles, stall_n;
        logic [3:0]  be_e;
        logic [31:0] wd_e;
        is_st  = wr;
        nbytes = 1 << f3[1:0];
        if (is_st) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else       legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        legal = legal && ((a % nbytes) == 0);
        be_e = 4'hF;
        wd_e = '0;
        if (legal && is_st) begin
            be_e = '0;
            for (int i = 0; i < int'(nbytes); i++) be_e[(a % 4) + i] = 1'b1;
            for (int lane = 0; lane < 4; lane++)
                wd_e[8 * lane +: 8] = wd[8 * (lane % nbytes) +: 8];
        end
        timeout    = (waits >= int'(TO));
        bus_cycles = timeout ? TO : waits + 1;

        memRead = rd; memWrite = wr; funct3 = f3; addr = a; writeData = wd; busAck = 1'b0;
        @(negedge clk);
        chk("stall_req_cycle", stall, legal);
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0;

        if (!legal) begin
            chk("fault_pulse", fault, 1'b1);
            chk("fault_no_busreq", busReq, 1'b0);
            chk("fault_no_stall", stall, 1'b0);
            chk("fault_readdata_kept", readData, rd_model);
            chk("fault_no_buserr", busErr, 1'b0);
            @(posedge clk); #1;
            chk("fault_one_cycle", fault, 1'b0);
            return;
        end

        chk("busreq_set", busReq, 1'b1);
        chk("buswe", busWe, is_st);
        chk("busaddr", busAddr, a & 32'hFFFF_FFFC);
        chk("busbe", busBe, be_e);
        if (is_st) chk("buswdata", busWdata, wd_e);

        stall_n = 1; stable = 1; done = 0;
        for (int n = 0; n < 400; n++) begin
            busAck   = (n == waits);
            busRdata = (n == waits) ? rdat : $urandom;
            @(negedge clk);
            if (!stall) begin done = 1; break; end
            stall_n++;
            if (busReq !== 1'b1 || busWe !== is_st || busAddr !== (a & 32'hFFFF_FFFC) ||
                busBe !== be_e || (is_st && busWdata !== wd_e)) stable = 0;
            @(posedge clk); #1;
        end
        chk("bus_wait_bounded", done, 1'b1);
        chk("bus_held_stable", stable, 1'b1);
        chk("stall_cycles", stall_n, 1 + bus_cycles);
        chk("busreq_dropped", busReq, 1'b0);
        chk("buserr", busErr, timeout);
        chk("no_fault", fault, 1'b0);
        if (!is_st) rd_model = timeout ? 32'd0 : model_load(f3, a, rdat);
        chk("readdata", readData, rd_model);
        busAck   = ack_in_done;
        busRdata = $urandom;
        @(posedge clk); #1;
        busAck = 1'b0;
        chk("buserr_one_cycle", busErr, 1'b0);
        if (ack_in_done) chk("done_ack_ignored", readData, rd_model);
    endtask

    initial begin
        reset = 1'b1; memRead = 1'b1; memWrite = 1'b0; funct3 = 3'd2; addr = 32'h40;
        writeData = '0; busAck = 1'b1; busRdata = 32'hFFFF_FFFF;
        rd_model = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_busreq", busReq, 1'b0);
        chk("rst_buswe", busWe, 1'b0);
        chk("rst_busaddr", busAddr, 32'd0);
        chk("rst_buswdata", busWdata, 32'd0);
        chk("rst_busbe", busBe, 4'd0);
        chk("rst_readdata", readData, 32'd0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_buserr", busErr, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; memRead = 1'b0; busAck = 1'b0;
        @(posedge clk); #1;

        // lb sign-extended, ack in first BUS cycle
        access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 1'b0);
        chk("lb_value", readData, 32'hFFFF_FF80);
        // sh with three wait cycles
        access(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h0, 3, 1'b0);
        // misaligned lw: fault, readData kept
        access(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 0, 1'b0);
        // illegal store funct3
        access(1'b0, 1'b1, 3'b100, 32'h8, 32'h1234, 32'h0, 0, 1'b0);
        // timeout on lw
        access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1000, 1'b0);
        chk("timeout_readdata", readData, 32'd0);

        // reset in the second BUS cycle of sw, with a simultaneous ack
        memRead = 1'b0; memWrite = 1'b1; funct3 = 3'b010; addr = 32'h10; writeData = 32'hCAFE_F00D;
        @(posedge clk); #1;
        memWrite = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; busAck = 1'b1;
        @(negedge clk);
        chk("midrst_stall", stall, 1'b0);
        @(posedge clk); #1;
        chk("midrst_busreq", busReq, 1'b0);
        chk("midrst_buswe", busWe, 1'b0);
        chk("midrst_busaddr", busAddr, 32'd0);
        chk("midrst_buswdata", busWdata, 32'd0);
        chk("midrst_busbe", busBe, 4'd0);
        chk("midrst_buserr", busErr, 1'b0);
        reset = 1'b0; busAck = 1'b0; rd_model = '0;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_AB00, 0, 1'b0);
        chk("lbu_after_reset", readData, 32'h0000_00AB);

        // back-to-back lw/sw with an ack during DONE, then read+write priority
        access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'h1357_9BDF, 0, 1'b1);
        access(1'b0, 1'b1, 3'b010, 32'h84, 32'hA5A5_5A5A, 32'h0, 0, 1'b1);
        access(1'b1, 1'b1, 3'b010, 32'h88, 32'h0102_0304, 32'hFFFF_FFFF, 1, 1'b0);
        access(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 32'h8001_7FFF, 2, 1'b0);
        access(1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 32'h8001_7FFF, 0, 1'b0);

        // randomized accesses
        for (int k = 0; k < 60; k++) begin
            logic r, w;
            int wt;
            r  = 1'($urandom);
            w  = 1'($urandom);
            if (!r && !w) r = 1'b1;
            wt = ($urandom_range(0, 9) == 0) ? int'(TO) + $urandom_range(0, 3) : $urandom_range(0, 4);
            access(r, w, 3'($urandom), $urandom, $urandom, $urandom, wt, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the `dataPath` memory port and a word-wide data-memory bus with variable wait states. Takes the core's ALU address, store data and access type, issues one bus transaction per access, and stalls the core until the bus acknowledges. Generates byte enables for stores, and sign- or zero-extends loaded data before returning it as `readData`. Rejects misaligned and illegal accesses without touching the bus.

## Interface
- `TIMEOUT`, default 15: maximum bus wait cycles before a transaction is aborted with an error; range 1–255.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `memRead`  in  1  core requests a load.
- `memWrite`  in  1  core requests a store; wins if both request signals are high.
- `funct3`  in  3  access type, using RV32I load/store encodings.
- `addr`  in  32  byte address (`aluResult`).
- `writeData`  in  32  store data, taken from the low bits.
- `readData`  out  32  extended load result; registered.
- `stall`  out  1  core must hold PC and instruction.
- `fault`  out  1  one-cycle pulse: misaligned or illegal access.
- `busErr`  out  1  one-cycle pulse: bus timeout.
- `busReq`  out  1  bus request; registered.
- `busWe`  out  1  bus write enable.
- `busAddr`  out  32  word-aligned address, with `addr[1:0]` forced to 0.
- `busWdata`  out  32  lane-replicated store data.
- `busBe`  out  4  byte enables.
- `busAck`  in  1  bus completes the transaction this cycle.
- `busRdata`  in  32  read data, valid when `busAck` is high.

## Operation
- **States:** IDLE, BUS, DONE.
- **IDLE, no request** (`memRead` and `memWrite` both low): stay in IDLE.
- **IDLE, request present:** check the access. If it is legal, register the bus outputs, set `busReq`=1 and go to BUS. If it is not legal, pulse `fault` on the next cycle, stay in IDLE, and leave `readData` unchanged. No store occurs.
- **Alignment rules:**
  - `lw`/`sw` require `addr[1:0]`=0.
  - `lh`/`lhu`/`sh` require `addr[0]`=0.
  - Byte accesses are always aligned.
- **Illegal funct3 values:**
  - Loads: 011, 110, 111.
  - Stores: any value other than 000, 001, 010.
- **BUS state:**
  - `busReq`, `busWe`, `busAddr`, `busWdata` and `busBe` are held stable.
  - Wait counter increments each cycle.
  - On `busAck`: capture the extended `busRdata` into `readData` (loads only), drop `busReq`, go to DONE.
  - When the counter reaches `TIMEOUT` with no `busAck`: drop `busReq`, pulse `busErr`, set `readData`=0 for loads, go to DONE.
- **DONE:** `stall`=0 for exactly one cycle while the core retires the instruction. Request inputs are ignored. Then go to IDLE.
- **Stores:** `busWdata` replicates the byte or half across lanes.
  - `sb`: `busBe`=0001<<`addr[1:0]`.
  - `sh`: `busBe`=0011<<`addr[1:0]`.
  - `sw`: `busBe`=1111.
- **Loads:** `busBe`=1111 and `busWe`=0. The lane is selected by `addr[1:0]`.
  - `lb` and `lh` sign-extend.
  - `lbu` and `lhu` zero-extend.
- **`stall` (combinational):**
  - High in IDLE when a legal request is present.
  - High throughout BUS.
  - Low otherwise.

## Timing
- **Reset values:** every registered output is 0 (`readData`, `busReq`, `busWe`, `busAddr`, `busWdata`, `busBe`, `fault`, `busErr`). State = IDLE, counter = 0, and `stall`=0 while `reset` is high.
- **Reset mid-transaction:** on the first edge with `reset` high, return to IDLE and drop `busReq`. A `busAck` arriving in the same cycle is ignored.
- **Latency with zero wait states:**
  - Cycle 0: request presented, `stall`=1.
  - Cycle 1: `busReq`=1; `busAck`=1 is allowed in this cycle.
  - Cycle 2: DONE, `readData` valid, `stall`=0.
- Each bus wait cycle adds one cycle. Minimum access is 3 cycles.
- Back-to-back accesses have one idle cycle between them, imposed by DONE.
- `busAck` outside the BUS state is ignored.
- `fault` and `busErr` are single-cycle pulses and are never asserted together.

## Structure
- **Shared package `riscv_mem_pkg`:**
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The state enum (IDLE/BUS/DONE).
  - The default `TIMEOUT`.
- **Sub-module `load_extend`:** combinational lane select plus sign/zero extension (inputs `busRdata`, `addr[1:0]`, `funct3`). It is reused later by any cache refill path.
- The FSM, wait counter, store lane/byte-enable generation and legality check all stay in `load_store_unit`.

## Test plan
- **Byte load, sign-extended:** `lb` at `addr`=0x0000_0103, `busRdata`=0x80FF_0000, `busAck` in the first BUS cycle → `busAddr`=0x100, `busBe`=1111, `readData`=0xFFFF_FF80, `stall` high for exactly 2 cycles.
- **Halfword store:** `sh` at `addr`=0x22, `writeData`=0x0000_BEEF, `busAck` after 3 wait cycles → `busWe`=1, `busAddr`=0x20, `busBe`=1100, `busWdata`=0xBEEF_BEEF, `stall` high for 5 cycles.
- **Misaligned word load:** `lw` at `addr`=0x6 → `fault` pulses once, `busReq` stays 0, `stall` stays 0, `readData` unchanged.
- **Timeout:** `lw` at 0x40 with `busAck` never asserted and `TIMEOUT`=15 → `busReq` high for 15 cycles, then `busErr` pulses, `readData`=0, returns to IDLE.
- **Reset mid-access:** `reset` asserted in the second BUS cycle of `sw` 0x10 → `busReq`=0 next edge, all outputs 0, state IDLE. Next `lbu` 0x11 with `busRdata`=0x0000_AB00 → `readData`=0x0000_00AB.
- **Back-to-back and request priority:** `lw` then `sw` with zero wait → one DONE cycle separates the two `busReq` pulses. A `busAck` in DONE is ignored. `memRead`=`memWrite`=1 issues a write.
